kamus_if: RTL and testbench
===========================

KAMUS_IF -- requirements
Module: kamus_IF

Interface
REQ-001 Parameter BOOT_ADDR, 32'h0000_0000, PC loaded at reset; bits [1:0] SHALL be zero.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous and active-low.
REQ-004 redirect_i  input  1  flush the pipeline and restart fetch at redirect_pc_i (branch, jump or trap).
REQ-005 redirect_pc_i  input  32  new fetch address; bits [1:0] SHALL be ignored and treated as 0.
REQ-006 imem_req_o  output  1  instruction memory request.
REQ-007 imem_addr_o  output  32  word-aligned request address.
REQ-008 imem_gnt_i  input  1  request accepted this cycle.
REQ-009 imem_rvalid_i  input  1  response valid; responses SHALL arrive in order, at least 1 cycle after their grant.
REQ-010 imem_rdata_i  input  32  response instruction word.
REQ-011 instr_valid_o  output  1  instr_o and pc_o valid for the decoder.
REQ-012 instr_o  output  32  fetched instruction word.
REQ-013 pc_o  output  32  address of instr_o.
REQ-014 instr_ready_i  input  1  decoder accepts the head entry this cycle.

Function
REQ-015 State SHALL consist of: fetch_pc (32), a 2-entry in-order FIFO of {instr, pc}, outstanding counter (0..2) and discard counter (0..2).
REQ-016 imem_req_o SHALL be 1 iff redirect_i=0 and (outstanding + fifo_count) < 2, using registered counts; a same-cycle pop SHALL NOT add credit.
REQ-017 imem_addr_o SHALL equal fetch_pc; while req=1 and gnt=0, req and addr SHALL hold stable.
REQ-018 On req and gnt: fetch_pc += 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0); outstanding += 1.
REQ-019 On rvalid: outstanding -= 1. If discard=0, push {imem_rdata_i, pc of that request} into the FIFO; otherwise drop the word and decrement discard.
REQ-020 pc of each pushed entry SHALL be tracked through a 2-entry in-order PC queue written on grant, or an equivalent mechanism.
REQ-021 A pushed word SHALL be visible on instr_o/pc_o with instr_valid_o=1 in the cycle after rvalid; there is no bypass path.
REQ-022 instr_valid_o = (fifo_count != 0); instr_o/pc_o SHALL show the FIFO head; when instr_valid_o=0, instr_o SHALL be 32'h0000_0013 (NOP) and pc_o SHALL be 0.
REQ-023 Pop when instr_valid_o and instr_ready_i; head entry SHALL be held unchanged while instr_ready_i=0.
REQ-024 Simultaneous push and pop SHALL keep fifo_count unchanged and preserve order.
REQ-025 Redirect cycle:
  - FIFO cleared.
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
  - discard <= outstanding - (imem_rvalid_i ? 1 : 0).
  - imem_req_o = 0.
  - Same-cycle pop and push SHALL have no effect.
REQ-026 First request to the redirect address SHALL be issued in the cycle after redirect_i, subject to REQ-016.
REQ-027 Back-to-back redirects: the last one SHALL win; discard SHALL be recomputed each cycle per REQ-025.
REQ-028 rvalid with outstanding=0 (stale response) SHALL be ignored.
REQ-029 FIFO overflow is impossible by construction; a push into a full FIFO SHALL fire a simulation assertion.

Reset
REQ-030 When rst_ni=0 at a clock edge, the following SHALL hold in the next cycle regardless of in-flight traffic:
  - fetch_pc = BOOT_ADDR.
  - FIFO empty.
  - outstanding = 0 and discard = 0.
  - imem_req_o = 0 and instr_valid_o = 0.
  - instr_o = 32'h0000_0013 and pc_o = 0.
REQ-031 The first request after reset SHALL be issued in the first cycle with rst_ni=1, addressing BOOT_ADDR.

Verification
REQ-032 Reset release, gnt=1 and zero-wait memory returning rdata=addr -> requests 0x0 and 0x4 on consecutive cycles; instr_o=0x0/pc_o=0x0 then 0x4/0x4; third request held until the first pop.
REQ-033 instr_ready_i=0 for 10 cycles -> FIFO holds pc 0x0 and 0x4, imem_req_o=0; after ready=1, outputs pc 0x0 then 0x4 with no loss or duplication.
REQ-034 Redirect to 0x100 with 2 outstanding, rvalid arriving in the redirect cycle and the next cycle -> both old words dropped; next valid output is pc_o=0x100.
REQ-035 Redirect to 0x203 -> imem_addr_o=0x200 and pc_o=0x200.
REQ-036 Fetch from 0xFFFF_FFFC -> next request address 0x0000_0000.
REQ-037 Reset asserted with 2 outstanding, memory then returning 2 stale rvalids -> no instr_valid_o until the BOOT_ADDR response arrives.

Source files
------------

// File: rtl/kamus_if_if.sv
// Fetch-unit bus bundle: instruction memory request/response, redirect and decoder handoff.
interface kamus_if_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;

  // Fetch unit side
  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o
  );

  // Memory / core / decoder side
  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o
  );
endinterface

// File: rtl/kamus_if.sv
// kamus_if: instruction fetch stage with a 2-deep credit window (outstanding + buffered),
// in-order response FIFO to the decoder and redirect flushing with stale-response discard.
module kamus_if #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  kamus_if_if.master bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  fifo_instr_q [2];
  logic [XLEN-1:0]  fifo_instr_d [2];
  logic [XLEN-1:0]  fifo_pc_q [2];
  logic [XLEN-1:0]  fifo_pc_d [2];
  logic             fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [XLEN-1:0]  pcq_q [2];
  logic [XLEN-1:0]  pcq_d [2];
  logic             pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic req_c, grant_c, rsp_c, push_c, pop_c, valid_c;

  // Handshake strobes from registered counts; a same-cycle pop never adds credit
  always_comb begin
    valid_c = (fifo_cnt_q != '0);
    req_c   = rst_ni && !bus.redirect_i &&
              ((SUM_W'(outst_q) + SUM_W'(fifo_cnt_q)) < SUM_W'(2));
    grant_c = req_c && bus.imem_gnt_i;
    rsp_c   = bus.imem_rvalid_i && (outst_q != '0);
    push_c  = rsp_c && (discard_q == '0) && !bus.redirect_i;
    pop_c   = valid_c && bus.instr_ready_i && !bus.redirect_i;
  end

  // Next-state: PC queue on grant, FIFO push/pop, counters, redirect flush
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_rd_d    = fifo_rd_q;
    fifo_wr_d    = fifo_wr_q;
    fifo_cnt_d   = fifo_cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    pcq_d        = pcq_q;
    pcq_rd_d     = pcq_rd_q;
    pcq_wr_d     = pcq_wr_q;
    outst_d      = outst_q + CNT_W'(grant_c) - CNT_W'(rsp_c);
    discard_d    = discard_q;

    if (grant_c) begin
      pcq_d[pcq_wr_q] = fetch_pc_q;
      pcq_wr_d        = ~pcq_wr_q;
      fetch_pc_d      = fetch_pc_q + XLEN'(4);
    end
    if (rsp_c) begin
      pcq_rd_d = ~pcq_rd_q;
      if (discard_q != '0) discard_d = discard_q - CNT_W'(1);
    end
    if (push_c) begin
      fifo_instr_d[fifo_wr_q] = bus.imem_rdata_i;
      fifo_pc_d[fifo_wr_q]    = pcq_q[pcq_rd_q];
      fifo_wr_d               = ~fifo_wr_q;
    end
    if (pop_c) fifo_rd_d = ~fifo_rd_q;

    // Everything still in flight after this cycle belongs to the old stream
    if (bus.redirect_i) begin
      fetch_pc_d = bus.redirect_pc_i & ALIGN_MASK;
      fifo_cnt_d = '0;
      fifo_rd_d  = 1'b0;
      fifo_wr_d  = 1'b0;
      discard_d  = outst_q - CNT_W'(rsp_c);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q   <= BOOT_ADDR & ALIGN_MASK;
      fifo_instr_q <= '{default: '0};
      fifo_pc_q    <= '{default: '0};
      fifo_rd_q    <= 1'b0;
      fifo_wr_q    <= 1'b0;
      fifo_cnt_q   <= '0;
      pcq_q        <= '{default: '0};
      pcq_rd_q     <= 1'b0;
      pcq_wr_q     <= 1'b0;
      outst_q      <= '0;
      discard_q    <= '0;
    end else begin
      assert (!(push_c && fifo_cnt_q == CNT_W'(2)));
      fetch_pc_q   <= fetch_pc_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      pcq_q        <= pcq_d;
      pcq_rd_q     <= pcq_rd_d;
      pcq_wr_q     <= pcq_wr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
    end
  end

  assign bus.imem_req_o    = req_c;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = valid_c;
  assign bus.instr_o       = valid_c ? fifo_instr_q[fifo_rd_q] : NOP_INSTR;
  assign bus.pc_o          = valid_c ? fifo_pc_q[fifo_rd_q] : '0;
endmodule

// File: tb/tb_kamus_if.sv
// Bench for kamus_if: reset table, directed corner sequences, randomized traffic vs. queue model.
module tb_kamus_if;
  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] KEY  = 32'h5A5A_0F0F;

  logic clk;
  logic rst_ni;
  kamus_if_if bus ();

  kamus_if #(.BOOT_ADDR(BOOT)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  logic        s_req, s_vld;
  logic [31:0] s_addr, s_instr, s_pc;

  typedef struct { logic [31:0] pc; bit stale; } pend_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  logic [31:0] m_pc;
  pend_t       m_pend[$];
  ent_t        m_fifo[$];
  mreq_t       mq[$];

  typedef struct {
    bit gnt; bit rv; logic [31:0] rdata; bit rdy;
    bit req; logic [31:0] addr; bit vld; logic [31:0] instr; logic [31:0] pc;
  } vec_t;
  vec_t tbl[9];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic sample();
    s_req   = bus.imem_req_o;
    s_addr  = bus.imem_addr_o;
    s_vld   = bus.instr_valid_o;
    s_instr = bus.instr_o;
    s_pc    = bus.pc_o;
  endtask

  task automatic model_reset();
    m_pc = BOOT;
    m_pend.delete();
    m_fifo.delete();
  endtask

  // One clock cycle: memory responds in order, DUT outputs compared with the queue model
  task automatic step(input bit rst_v, input bit redir, input logic [31:0] rpc,
                      input bit rdy, input bit gnt_v, input int lat);
    bit          rv, deliver, e_req, e_vld;
    logic [31:0] rd, e_instr, e_pc;
    mreq_t       m;
    pend_t       p;
    @(negedge clk);
    cyc++;
    rv = 1'b0;
    rd = 32'hDEAD_BEEF;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      m  = mq.pop_front();
      rv = 1'b1;
      rd = mem_word(m.addr);
    end
    rst_ni            = rst_v;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.instr_ready_i = rdy;
    bus.imem_gnt_i    = gnt_v;
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rd;
    #1;
    e_req   = rst_v && !redir && ((m_pend.size() + m_fifo.size()) < 2);
    e_vld   = (m_fifo.size() != 0);
    e_instr = e_vld ? m_fifo[0].instr : NOP;
    e_pc    = e_vld ? m_fifo[0].pc : 32'h0;
    sample();
    chk("mdl_req", 32'(s_req), 32'(e_req));
    chk("mdl_addr", s_addr, m_pc);
    chk("mdl_valid", 32'(s_vld), 32'(e_vld));
    chk("mdl_instr", s_instr, e_instr);
    chk("mdl_pc", s_pc, e_pc);
    if (bus.imem_req_o && gnt_v) mq.push_back('{addr: bus.imem_addr_o, due: cyc + lat});
    if (!rst_v) begin
      model_reset();
    end else begin
      deliver = 1'b0;
      p = '{pc: 32'h0, stale: 1'b0};
      if (rv && m_pend.size() > 0) begin
        p = m_pend.pop_front();
        deliver = !p.stale && !redir;
      end
      if (redir) begin
        m_fifo.delete();
        for (int i = 0; i < m_pend.size(); i++) m_pend[i].stale = 1'b1;
        m_pc = rpc & ~32'h3;
      end else begin
        if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (deliver) m_fifo.push_back('{instr: rd, pc: p.pc});
        if (e_req && gnt_v) begin
          m_pend.push_back('{pc: m_pc, stale: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // Fresh start: drop anything the memory still owes, then two reset cycles
  task automatic fresh();
    mq.delete();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1);
  endtask

  // Run until a valid instruction is seen (bounded); result left in s_* variables
  task automatic run_to_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
      seen = s_vld;
    end
    chk({name, "_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    bit any_vld;
    bit rd_b, gn_b, rdir;
    logic [31:0] rpc;
    rst_ni            = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.instr_ready_i = 1'b0;
    bus.imem_gnt_i    = 1'b1;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    model_reset();

    // Reset state, still in reset
    repeat (2) @(negedge clk);
    #1;
    sample();
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_valid", 32'(s_vld), 32'd0);
    chk("rst_instr", s_instr, NOP);
    chk("rst_pc", s_pc, 32'h0);
    chk("rst_addr", s_addr, BOOT);

    // Zero-wait memory returning rdata=addr, decoder stalls then drains
    //          gnt rv  rdata  rdy  req addr   vld instr  pc
    tbl[0] = '{1, 0, 32'h0, 0,  1, 32'h0, 0, NOP,   32'h0};
    tbl[1] = '{1, 1, 32'h0, 0,  1, 32'h4, 0, NOP,   32'h0};
    tbl[2] = '{1, 1, 32'h4, 0,  0, 32'h8, 1, 32'h0, 32'h0};
    tbl[3] = '{1, 0, 32'h0, 0,  0, 32'h8, 1, 32'h0, 32'h0};
    tbl[4] = '{1, 0, 32'h0, 1,  0, 32'h8, 1, 32'h0, 32'h0};
    tbl[5] = '{1, 0, 32'h0, 0,  1, 32'h8, 1, 32'h4, 32'h4};
    tbl[6] = '{0, 1, 32'h8, 1,  0, 32'hC, 1, 32'h4, 32'h4};
    tbl[7] = '{0, 0, 32'h0, 1,  1, 32'hC, 1, 32'h8, 32'h8};
    tbl[8] = '{0, 0, 32'h0, 0,  1, 32'hC, 0, NOP,   32'h0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rst_ni            = 1'b1;
      bus.redirect_i    = 1'b0;
      bus.imem_gnt_i    = tbl[i].gnt;
      bus.imem_rvalid_i = tbl[i].rv;
      bus.imem_rdata_i  = tbl[i].rdata;
      bus.instr_ready_i = tbl[i].rdy;
      #1;
      sample();
      chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(s_vld), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_instr", i), s_instr, tbl[i].instr);
      chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
    end

    // Resynchronise model and DUT
    @(negedge clk);
    rst_ni = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    @(negedge clk);
    model_reset();
    mq.delete();

    // Long decoder stall then drain in order
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    chk("stall_req", 32'(s_req), 32'd0);
    chk("stall_head_pc", s_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    chk("drain_first_pc", s_pc, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    chk("drain_second_pc", s_pc, 32'h4);
    chk("drain_second_vld", 32'(s_vld), 32'd1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);

    // Redirect with two outstanding; responses in the redirect cycle and the next
    fresh();
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 3);
    chk("redir_credit_req", 32'(s_req), 32'd0);
    step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1, 1);
    chk("redir_cycle_req", 32'(s_req), 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    chk("redir_next_addr", s_addr, 32'h100);
    chk("redir_next_vld", 32'(s_vld), 32'd0);
    run_to_valid("redir");
    chk("redir_first_pc", s_pc, 32'h100);
    chk("redir_first_instr", s_instr, mem_word(32'h100));

    // Misaligned redirect target
    fresh();
    step(1'b1, 1'b1, 32'h203, 1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    chk("unalign_addr", s_addr, 32'h200);
    run_to_valid("unalign");
    chk("unalign_pc", s_pc, 32'h200);

    // Fetch address wraps past the top of memory
    fresh();
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1);
    chk("wrap_addr1", s_addr, 32'h0);

    // Reset with two outstanding; stale responses arrive afterwards
    fresh();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 8);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 8);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1);
    chk("rst2_req", 32'(s_req), 32'd0);
    chk("rst2_vld", 32'(s_vld), 32'd0);
    chk("rst2_addr", s_addr, BOOT);
    any_vld = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1);
      any_vld = any_vld | s_vld;
    end
    chk("stale_no_valid", 32'(any_vld), 32'd0);
    chk("stale_mem_drained", 32'(mq.size()), 32'd0);
    run_to_valid("boot");
    chk("boot_pc", s_pc, BOOT);
    chk("boot_instr", s_instr, mem_word(BOOT));

    // Randomized traffic against the model
    fresh();
    for (int k = 0; k < 3000; k++) begin
      rdir = ($urandom_range(99) < 3);
      rpc  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : 32'($urandom);
      rd_b = ($urandom_range(9) < 6);
      gn_b = ($urandom_range(9) < 7);
      step(1'b1, rdir, rpc, rd_b, gn_b, int'($urandom_range(3, 1)));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
